// File: rtl/as65x_pkg.sv
// rtl/as65x_pkg.sv - shared FSM state encoding and parameter defaults for the AS65x bus arbiter
package as65x_pkg;

    localparam int STEAL_DELAY_DEF = 3;
    localparam int MAX_BURST_DEF   = 40;
    localparam int FAIR_GAP_DEF    = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HALT    = 3'd1,
        ST_GRANT   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_GAP     = 3'd4
    } state_e;

    // A delay of N cycles loads N-1; zero-length delays still spend one cycle in the state.
    function automatic int load_of(input int cycles);
        return (cycles > 0) ? cycles - 1 : 0;
    endfunction

endpackage

// File: rtl/as65x_cyc_counter.sv
// rtl/as65x_cyc_counter.sv - loadable down-counter that saturates at zero, used for HALT and GAP delays
module as65x_cyc_counter #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(negedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/as65x_bus_arbiter.sv
// rtl/as65x_bus_arbiter.sv - cycle-stealing DMA arbiter: halts the CPU via RDY, takes the bus via AEC
module as65x_bus_arbiter
    import as65x_pkg::*;
#(
    parameter int STEAL_DELAY = STEAL_DELAY_DEF,
    parameter int MAX_BURST   = MAX_BURST_DEF,
    parameter int FAIR_GAP    = FAIR_GAP_DEF
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        dma_req,
    input  logic [15:0] dma_addr,
    input  logic        dma_rwn,
    input  logic [7:0]  dma_wdata,
    input  logic [15:0] cpu_a,
    input  logic        cpu_a_oe,
    input  logic        cpu_rwn,
    input  logic [7:0]  cpu_d_o,
    input  logic        cpu_d_oe,
    output logic        rdy,
    output logic        aec,
    output logic        dma_grant,
    output logic [15:0] bus_a,
    output logic        bus_a_oe,
    output logic        bus_rwn,
    output logic [7:0]  bus_d_o,
    output logic        bus_d_oe,
    output logic        burst_trunc
);

    localparam int CNT_MAX = (STEAL_DELAY > FAIR_GAP) ? STEAL_DELAY : FAIR_GAP;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BW      = $clog2(MAX_BURST + 1);

    localparam logic [CW-1:0] STEAL_LOAD = CW'(load_of(STEAL_DELAY));
    localparam logic [CW-1:0] GAP_LOAD   = CW'(load_of(FAIR_GAP));
    localparam logic [BW-1:0] BEAT_LAST  = BW'(MAX_BURST);

    state_e          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            trunc_q, trunc_d;
    logic            rdy_q, rdy_d;
    logic            aec_q, aec_d;
    logic            grant_q, grant_d;
    logic            cnt_load;
    logic [CW-1:0]   cnt_load_val;
    logic            cnt_dec;
    logic            cnt_zero;

    as65x_cyc_counter #(
        .W (CW)
    ) u_delay_cnt (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        trunc_d      = trunc_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dma_req) begin
                    state_d      = ST_HALT;
                    cnt_load     = 1'b1;
                    cnt_load_val = STEAL_LOAD;
                end
            end
            // Wait out any CPU write run: the 65xx ignores RDY during writes.
            ST_HALT: begin
                if (!dma_req) begin
                    state_d      = ST_GAP;
                    cnt_load     = 1'b1;
                    cnt_load_val = GAP_LOAD;
                end else if (cnt_zero && cpu_rwn) begin
                    state_d = ST_GRANT;
                    beat_d  = BW'(1);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!dma_req) begin
                    state_d = ST_RELEASE;
                    trunc_d = 1'b0;
                    beat_d  = '0;
                end else if (beat_q >= BEAT_LAST) begin
                    state_d = ST_RELEASE;
                    trunc_d = 1'b1;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            ST_RELEASE: begin
                state_d      = ST_GAP;
                cnt_load     = 1'b1;
                cnt_load_val = GAP_LOAD;
            end
            ST_GAP: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Control outputs are decoded from the next state and registered, so they never glitch.
    always_comb begin
        rdy_d   = 1'b1;
        aec_d   = 1'b1;
        grant_d = 1'b0;
        case (state_d)
            ST_HALT:    rdy_d = 1'b0;
            ST_RELEASE: rdy_d = 1'b0;
            ST_GRANT: begin
                rdy_d   = 1'b0;
                aec_d   = 1'b0;
                grant_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(negedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            trunc_q <= 1'b0;
            rdy_q   <= 1'b1;
            aec_q   <= 1'b1;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            trunc_q <= trunc_d;
            rdy_q   <= rdy_d;
            aec_q   <= aec_d;
            grant_q <= grant_d;
        end
    end

    assign rdy         = rdy_q;
    assign aec         = aec_q;
    assign dma_grant   = grant_q;
    assign burst_trunc = trunc_q;

    always_comb begin
        if (grant_q) begin
            bus_a    = dma_addr;
            bus_a_oe = 1'b1;
            bus_rwn  = dma_rwn;
            bus_d_o  = dma_wdata;
            bus_d_oe = !dma_rwn;
        end else begin
            bus_a    = cpu_a;
            bus_a_oe = cpu_a_oe;
            bus_rwn  = cpu_rwn;
            bus_d_o  = cpu_d_o;
            bus_d_oe = cpu_d_oe;
        end
    end

endmodule

// File: tb/tb_as65x_bus_arbiter.sv
// tb/tb_as65x_bus_arbiter.sv - directed self-checking bench for as65x_bus_arbiter
module tb_as65x_bus_arbiter;

    logic        clk_i;
    logic        rst_n;
    logic        dma_req;
    logic [15:0] dma_addr;
    logic        dma_rwn;
    logic [7:0]  dma_wdata;
    logic [15:0] cpu_a;
    logic        cpu_a_oe;
    logic        cpu_rwn;
    logic [7:0]  cpu_d_o;
    logic        cpu_d_oe;
    logic        rdy;
    logic        aec;
    logic        dma_grant;
    logic [15:0] bus_a;
    logic        bus_a_oe;
    logic        bus_rwn;
    logic [7:0]  bus_d_o;
    logic        bus_d_oe;
    logic        burst_trunc;

    int total = 0;
    int fails = 0;

    as65x_bus_arbiter dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .dma_req     (dma_req),
        .dma_addr    (dma_addr),
        .dma_rwn     (dma_rwn),
        .dma_wdata   (dma_wdata),
        .cpu_a       (cpu_a),
        .cpu_a_oe    (cpu_a_oe),
        .cpu_rwn     (cpu_rwn),
        .cpu_d_o     (cpu_d_o),
        .cpu_d_oe    (cpu_d_oe),
        .rdy         (rdy),
        .aec         (aec),
        .dma_grant   (dma_grant),
        .bus_a       (bus_a),
        .bus_a_oe    (bus_a_oe),
        .bus_rwn     (bus_rwn),
        .bus_d_o     (bus_d_o),
        .bus_d_oe    (bus_d_oe),
        .burst_trunc (burst_trunc)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int g;
        int bad;
        rst_n     = 1'b1;
        dma_req   = 1'b0;
        dma_addr  = 16'hC000;
        dma_rwn   = 1'b1;
        dma_wdata = 8'hA5;
        cpu_a     = 16'h1234;
        cpu_a_oe  = 1'b1;
        cpu_rwn   = 1'b1;
        cpu_d_o   = 8'h55;
        cpu_d_oe  = 1'b0;
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_rdy", rdy, 1);
        check("rst_aec", aec, 1);
        check("rst_grant", dma_grant, 0);
        check("rst_trunc", burst_trunc, 0);
        check("rst_bus_a", bus_a, 16'h1234);
        rst_n = 1'b1;
        tick();

        // Scenario 1: three HALT cycles then grant
        dma_req = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("s1_halt_rdy", rdy, 0);
            check("s1_halt_aec", aec, 1);
            check("s1_halt_grant", dma_grant, 0);
        end
        tick();
        check("s1_grant", dma_grant, 1);
        check("s1_aec", aec, 0);
        check("s1_bus_a", bus_a, 16'hC000);
        check("s1_bus_a_oe", bus_a_oe, 1);
        check("s1_bus_d_oe", bus_d_oe, 0);

        // Scenario 3: request held, burst cut at 40 beats
        g = 1;
        bad = 0;
        for (int i = 0; i < 39; i++) begin
            tick();
            if (dma_grant === 1'b1) g++;
            if (dma_grant === 1'b1 && aec !== 1'b0) bad++;
        end
        check("s3_grant_beats", g, 40);
        check("s3_grant_aec_overlap", bad, 0);
        tick();
        check("s3_release_grant", dma_grant, 0);
        check("s3_release_aec", aec, 1);
        check("s3_release_rdy", rdy, 0);
        check("s3_trunc", burst_trunc, 1);
        check("s3_release_bus_a", bus_a, 16'h1234);
        tick();
        check("s3_gap1_rdy", rdy, 1);
        tick();
        check("s3_gap2_rdy", rdy, 1);
        tick();
        check("s3_idle_rdy", rdy, 1);
        tick();
        check("s3_rehalt_rdy", rdy, 0);
        check("s3_rehalt_aec", aec, 1);

        // Scenario 4: request withdrawn during HALT
        dma_req = 1'b0;
        g = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (dma_grant !== 1'b0) g++;
            check("s4_rdy", rdy, 1);
        end
        check("s4_no_grant", g, 0);
        check("s4_trunc_sticky", burst_trunc, 1);

        // Scenario 2: CPU writes stretch the HALT
        cpu_rwn  = 1'b0;
        dma_addr = 16'h8000;
        dma_req  = 1'b1;
        g = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (dma_grant !== 1'b0) g++;
        end
        check("s2_no_early_grant", g, 0);
        check("s2_halt_rdy", rdy, 0);
        cpu_rwn = 1'b1;
        tick();
        check("s2_grant", dma_grant, 1);
        check("s2_bus_a", bus_a, 16'h8000);
        dma_req = 1'b0;
        tick();
        check("s2_release_grant", dma_grant, 0);
        check("s2_trunc_clear", burst_trunc, 0);
        tick();
        tick();
        tick();

        // Scenario 6: DMA write, CPU data must stay off the bus
        dma_addr  = 16'hD020;
        dma_wdata = 8'h0E;
        dma_rwn   = 1'b0;
        cpu_d_oe  = 1'b1;
        #1;
        check("s6_idle_pass_d", bus_d_o, 8'h55);
        check("s6_idle_pass_oe", bus_d_oe, 1);
        dma_req = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("s6_grant", dma_grant, 1);
        check("s6_bus_a", bus_a, 16'hD020);
        check("s6_bus_d_o", bus_d_o, 8'h0E);
        check("s6_bus_d_oe", bus_d_oe, 1);
        check("s6_bus_rwn", bus_rwn, 0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            cpu_d_o = 8'h60 + 8'(i);
            #1;
            if (bus_d_o !== 8'h0E) bad++;
            tick();
            if (bus_d_o !== 8'h0E || dma_grant !== 1'b1) bad++;
        end
        check("s6_cpu_data_leak", bad, 0);

        // Scenario 5: reset at grant beat 7
        cpu_d_o = 8'h77;
        #2 rst_n = 1'b0;
        #1;
        check("s5_async_grant", dma_grant, 0);
        check("s5_async_aec", aec, 1);
        check("s5_async_rdy", rdy, 1);
        check("s5_async_bus_d", bus_d_o, 8'h77);
        check("s5_async_bus_a", bus_a, 16'h1234);
        tick();
        rst_n   = 1'b1;
        dma_req = 1'b0;
        tick();
        check("s5_idle_rdy", rdy, 1);
        check("s5_idle_grant", dma_grant, 0);
        check("s5_idle_aec", aec, 1);
        check("s5_idle_trunc", burst_trunc, 0);
        cpu_a = 16'hFFFC;
        #1;
        check("s5_idle_bus_a", bus_a, 16'hFFFC);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/as65x_bus_arbiter.md
AS65X_BUS_ARBITER -- requirements
Module: as65x_bus_arbiter

Interface
REQ-001 SHALL have parameter STEAL_DELAY, default 3, meaning cycles RDY is held low before AEC is dropped (covers the longest CPU write run).
REQ-002 SHALL have parameter MAX_BURST, default 40, meaning the maximum DMA cycles per grant.
REQ-003 SHALL have parameter FAIR_GAP, default 2, meaning the minimum CPU-owned cycles between two grants.
REQ-004 SHALL have port clk_i  in  1  CPU phase clock (PH0IN domain).
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port dma_req  in  1  DMA requester wants the bus.
REQ-007 SHALL have ports dma_addr  in  16, dma_rwn  in  1, and dma_wdata  in  8, carrying the DMA address, direction (1 = read) and write data.
REQ-008 SHALL have ports cpu_a  in  16, cpu_a_oe  in  1, cpu_rwn  in  1, cpu_d_o  in  8, and cpu_d_oe  in  1, carrying the CPU bus outputs.
REQ-009 SHALL have ports rdy  out  1 and aec  out  1, the CPU RDY and AEC inputs.
REQ-010 SHALL have port dma_grant  out  1  DMA owns the bus this cycle.
REQ-011 SHALL have ports bus_a  out  16, bus_a_oe  out  1, bus_rwn  out  1, bus_d_o  out  8, and bus_d_oe  out  1, carrying the muxed external bus.
REQ-012 SHALL have port burst_trunc  out  1  sticky flag: the last burst was cut off by MAX_BURST.

Function
REQ-013 SHALL update all state on the falling edge of clk_i, matching the CPU register phase.
REQ-014 SHALL implement the FSM IDLE -> HALT -> GRANT -> RELEASE -> GAP -> IDLE.
REQ-015 IDLE: rdy=1, aec=1, dma_grant=0; dma_req=1 sampled -> HALT, with the counter loaded to STEAL_DELAY-1.
REQ-016 HALT: rdy=0, aec=1; decrement the counter each cycle; leave for GRANT only when the counter is 0 and cpu_rwn=1, otherwise hold at 0.
REQ-017 HALT: if dma_req drops, go to GAP without granting, and never assert dma_grant.
REQ-018 GRANT: rdy=0, aec=0, dma_grant=1; count beats from 1; bus_a=dma_addr, bus_rwn=dma_rwn, bus_a_oe=1; bus_d_o=dma_wdata and bus_d_oe=!dma_rwn.
REQ-019 GRANT ends (-> RELEASE) when dma_req=0 is sampled, or on the beat where the count equals MAX_BURST.
REQ-020 GRANT: if MAX_BURST ends the burst while dma_req=1, set burst_trunc; if dma_req=0 ends it, clear burst_trunc.
REQ-021 RELEASE: single cycle, aec=1, rdy=0, dma_grant=0, bus returns to the CPU; -> GAP with the counter loaded to FAIR_GAP-1.
REQ-022 GAP: rdy=1, aec=1; a new dma_req is ignored until the counter reaches 0; then -> IDLE.
REQ-023 If FAIR_GAP=0, GAP SHALL last exactly one cycle.
REQ-024 In every state except GRANT, the bus_* outputs SHALL equal the corresponding cpu_* inputs combinationally.
REQ-025 dma_grant, aec and rdy SHALL be registered outputs, glitch-free.
REQ-026 dma_grant=1 SHALL never coincide with aec=1.
REQ-027 An unreachable state encoding SHALL recover to IDLE on the next edge.
REQ-028 The beat counter width SHALL be $clog2(MAX_BURST+1).
REQ-029 The beat counter SHALL saturate and never wrap.

Reset
REQ-030 While rst_n=0, the block SHALL be in IDLE with rdy=1, aec=1, dma_grant=0, burst_trunc=0, counters 0, and the bus muxed to the CPU.
REQ-031 Reset asserted mid-HALT or mid-GRANT SHALL drop dma_grant immediately (asynchronously), with no RELEASE cycle.

Structure
REQ-032 A shared package as65x_pkg SHALL hold the FSM state enum and the parameter defaults.
REQ-033 The block SHALL contain one sub-module, as65x_cyc_counter: a loadable, saturating down-counter used for the HALT and GAP delays.

Verification
REQ-034 Scenario 1: dma_req=1 with cpu_rwn=1 -> rdy low for 3 cycles, then aec=0 and dma_grant=1 on the 4th cycle, and bus_a=dma_addr.
REQ-035 Scenario 2: cpu_rwn=0 for the first 5 HALT cycles -> the grant is delayed until the first cycle with cpu_rwn=1 after the counter reaches 0.
REQ-036 Scenario 3: dma_req held high for 60 cycles, MAX_BURST=40 -> exactly 40 grant cycles, burst_trunc=1, RELEASE, 2 GAP cycles with rdy=1, then re-HALT.
REQ-037 Scenario 4: dma_req pulsed for 1 cycle then dropped during HALT -> no grant, FSM reaches GAP then IDLE, and rdy returns to 1.
REQ-038 Scenario 5: rst_n pulled low at grant beat 7 -> dma_grant=0 and aec=1 immediately; after release, IDLE with the bus on the CPU.
REQ-039 Scenario 6: DMA write of dma_addr=0xD020, dma_wdata=0x0E, dma_rwn=0 -> bus_d_oe=1 and bus_d_o=0x0E, and the CPU data never reaches the bus during GRANT.
